// File: rtl/arm_pkg.sv
// Shared ARM datapath constants and the fetch buffer entry type.
package arm_pkg;

  localparam logic [31:0] PC_INC         = 32'd4;
  localparam logic [31:0] PC_READ_OFFSET = 32'd8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_pc_unit_fifo.sv
// fetch_fifo: power-of-two synchronous FIFO of fetch entries with flush and occupancy count.
module fetch_fifo
  import arm_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  fetch_entry_t  wdata_i,
  output fetch_entry_t  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_i) rd_q <= rd_q + AW'(1);
      if (push_i && !pop_i)      cnt_q <= cnt_q + CW'(1);
      else if (pop_i && !push_i) cnt_q <= cnt_q - CW'(1);
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC, credit-based imem requests, redirect/drop handling and decode-side buffer.
// Optional performance counters when FETCH_PERF_EN is defined.
module fetch_pc_unit
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        dec_ready,
  input  logic        br_taken,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_imm
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int unsigned CW = $clog2(IBUF_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(IBUF_DEPTH);

  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          fifo_push, fifo_pop;
  fetch_entry_t  fifo_head, fifo_wdata;

  logic [CW:0]   in_use;
  logic          grant;
  logic [31:0]   br_sum, br_target;

  assign in_use    = {1'b0, out_q} + {1'b0, fifo_count};
  assign imem_req  = !br_taken && (in_use < DEPTH_L);
  assign imem_addr = fpc_q;
  assign grant     = imem_req && imem_gnt;

  assign br_sum    = br_pc + PC_READ_OFFSET + br_imm;
  assign br_target = {br_sum[31:2], 2'b00};

  // Responses are in order and every stale one is dropped, so live data always
  // belongs to the address sequence starting at the last redirect target.
  assign fifo_push  = imem_rvalid && (drop_q == '0) && !br_taken && !fifo_full;
  assign fifo_pop   = dec_valid && dec_ready;
  assign fifo_wdata = '{pc: rsp_pc_q, instr: imem_rdata};

  assign dec_valid = !fifo_empty && !br_taken;
  assign dec_instr = fifo_head.instr;
  assign dec_pc    = fifo_head.pc;

  always_comb begin
    fpc_d    = fpc_q;
    rsp_pc_d = rsp_pc_q;
    out_d    = out_q;
    drop_d   = drop_q;

    if (br_taken)   fpc_d = br_target;
    else if (grant) fpc_d = fpc_q + PC_INC;

    if (br_taken)       rsp_pc_d = br_target;
    else if (fifo_push) rsp_pc_d = rsp_pc_q + PC_INC;

    if (grant && !imem_rvalid)      out_d = out_q + CW'(1);
    else if (!grant && imem_rvalid) out_d = out_q - CW'(1);

    if (br_taken)                         drop_d = out_q - (imem_rvalid ? CW'(1) : '0);
    else if (imem_rvalid && drop_q != '0) drop_d = drop_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fpc_q    <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      fpc_q    <= fpc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (IBUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (br_taken),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_flush_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (fifo_pop) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (br_taken) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized bench for fetch_pc_unit against a queue-based model of requests and the buffer.
module tb_fetch_pc_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] XOR_K    = 32'hE000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        dec_valid, dec_ready = 1'b0;
  logic [31:0] dec_instr, dec_pc;
  logic        br_taken = 1'b0;
  logic [31:0] br_pc = '0, br_imm = '0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt;
`endif

  fetch_pc_unit #(
    .RESET_PC   (RESET_PC),
    .IBUF_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .dec_valid   (dec_valid),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .dec_ready   (dec_ready),
    .br_taken    (br_taken),
    .br_pc       (br_pc),
    .br_imm      (br_imm)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit live; int gcyc; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  req_t        inflight[$];
  ent_t        ibuf[$];
  logic [31:0] popped[$];
  logic [31:0] m_fpc = RESET_PC;
  int          cyc = 0;
  int          n_checks = 0, n_errors = 0;
  int          m_pops = 0, m_flushes = 0;
  int          grants_seen = 0, first_gnt = -1, first_dv = -1;

  bit          rst_act = 1'b1, br = 1'b0, rdy = 1'b0;
  logic [31:0] bpc = '0, bimm = '0;
  int          gnt_p = 100, rv_p = 100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_pop(input string tag, input int idx, input logic [31:0] exp);
    logic [31:0] got;
    got = (popped.size() > idx) ? popped[idx] : 32'hxxxx_xxxx;
    check(tag, got, exp);
  endtask

  // One clock: drive inputs after the falling edge, compare just after, then advance the model.
  task automatic cycle();
    bit   m_req, m_dv;
    req_t r;
    @(negedge clk);
    reset_n = !rst_act;
    if (rst_act) begin
      inflight.delete();
      ibuf.delete();
      m_fpc     = RESET_PC;
      m_pops    = 0;
      m_flushes = 0;
    end
    imem_gnt    = ($urandom_range(99) < gnt_p);
    imem_rvalid = !rst_act && inflight.size() > 0 && inflight[0].gcyc < cyc &&
                  ($urandom_range(99) < rv_p);
    imem_rdata  = imem_rvalid ? (inflight[0].addr ^ XOR_K) : $urandom;
    dec_ready   = rdy;
    br_taken    = br && !rst_act;
    br_pc       = bpc;
    br_imm      = bimm;
    #1;
    m_req = !br_taken && (inflight.size() + ibuf.size() < DEPTH);
    m_dv  = ibuf.size() > 0 && !br_taken;
    check("imem_req", imem_req, m_req);
    check("imem_addr", imem_addr, m_fpc);
    check("dec_valid", dec_valid, m_dv);
    if (m_dv) begin
      check("dec_pc", dec_pc, ibuf[0].pc);
      check("dec_instr", dec_instr, ibuf[0].instr);
    end
    if (rst_act) begin
      check("rst_dec_instr", dec_instr, 32'h0);
      check("rst_dec_pc", dec_pc, 32'h0);
    end else begin
      if (imem_req && imem_gnt) begin
        grants_seen++;
        if (first_gnt < 0) first_gnt = cyc;
      end
      if (dec_valid && first_dv < 0) first_dv = cyc;
      if (dec_valid && dec_ready) popped.push_back(dec_pc);

      if (m_dv && dec_ready) begin
        void'(ibuf.pop_front());
        m_pops++;
      end
      if (imem_rvalid) begin
        r = inflight.pop_front();
        if (r.live && !br_taken) ibuf.push_back('{r.addr, r.addr ^ XOR_K});
      end
      if (m_req && imem_gnt) begin
        inflight.push_back('{m_fpc, 1'b1, cyc});
        m_fpc = m_fpc + 32'd4;
      end
      if (br_taken) begin
        ibuf.delete();
        foreach (inflight[i]) inflight[i].live = 1'b0;
        m_fpc = (bpc + 32'd8 + bimm) & 32'hFFFF_FFFC;
        m_flushes++;
      end
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst_act = 1'b1;
    br      = 1'b0;
    repeat (n) cycle();
    rst_act     = 1'b0;
    first_gnt   = -1;
    first_dv    = -1;
    grants_seen = 0;
    popped.delete();
  endtask

  initial begin
    logic [31:0] r;

    // Streaming after reset with a 1-cycle memory
    gnt_p = 100; rv_p = 100; rdy = 1'b1;
    do_reset(2);
    repeat (10) cycle();
    check("first_dec_latency", 32'(first_dv - first_gnt), 32'd2);
    check_pop("stream_pc0", 0, 32'h0);
    check_pop("stream_pc1", 1, 32'h4);
    check_pop("stream_pc2", 2, 32'h8);

    // Backpressure: credit stops requests at DEPTH
    rdy = 1'b0;
    do_reset(1);
    repeat (8) cycle();
    check("bp_grants", 32'(grants_seen), 32'(DEPTH));
    check("bp_req_held", imem_req, 1'b0);
    rdy = 1'b1;
    repeat (8) cycle();
    check_pop("bp_pc0", 0, 32'h0);
    check_pop("bp_pc1", 1, 32'h4);
    check_pop("bp_pc2", 2, 32'h8);

    // Forward branch with two requests still in flight
    do_reset(1);
    rv_p = 0;
    repeat (2) cycle();
    br = 1'b1; bpc = 32'h20; bimm = 32'h100;
    cycle();
    br = 1'b0;
    popped.delete();
    cycle();
    check("fwd_target", imem_addr, 32'h128);
    rv_p = 100;
    repeat (10) cycle();
    check_pop("fwd_first_pc", 0, 32'h128);

    // Backward branch coinciding with a response and a ready decode
    do_reset(1);
    repeat (2) cycle();
    br = 1'b1; bpc = 32'h10; bimm = 32'hFFFF_FFF8;
    cycle();
    br = 1'b0;
    popped.delete();
    cycle();
    check("bwd_target", imem_addr, 32'h10);
    check("bwd_flushed", dec_valid, 1'b0);
    repeat (8) cycle();
    check_pop("bwd_first_pc", 0, 32'h10);

    // Reset mid-stream with requests outstanding and a word buffered
    do_reset(1);
    rdy = 1'b0;
    repeat (2) cycle();
    rst_act = 1'b1;
    cycle();
    check("midrst_dec_valid", dec_valid, 1'b0);
    check("midrst_addr", imem_addr, RESET_PC);
    rdy = 1'b1;
    do_reset(1);
    repeat (8) cycle();
    check_pop("midrst_first_pc", 0, RESET_PC);

    // Address wrap at the top of memory
    br = 1'b1; bpc = 32'hFFFF_FFF0; bimm = 32'h4;
    cycle();
    br = 1'b0;
    popped.delete();
    repeat (10) cycle();
    check_pop("wrap_pc0", 0, 32'hFFFF_FFFC);
    check_pop("wrap_pc1", 1, 32'h0);

    // Random traffic
    do_reset(1);
    gnt_p = 70; rv_p = 60;
    for (int i = 0; i < 4000; i++) begin
      rdy  = ($urandom_range(3) != 0);
      br   = ($urandom_range(19) == 0);
      r    = $urandom;
      bpc  = $urandom & 32'hFFFF_FFFC;
      bimm = {{6{r[23]}}, r[23:0], 2'b00};
      rst_act = ($urandom_range(799) == 0);
      cycle();
    end
    rst_act = 1'b0;
    br = 1'b0;
    repeat (4) cycle();
`ifdef FETCH_PERF_EN
    check("perf_fetch_cnt", perf_fetch_cnt, 32'(m_pops));
    check("perf_flush_cnt", perf_flush_cnt, 32'(m_flushes));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
